instr_fetch_multi: RTL and testbench
====================================

INSTR_FETCH_MULTI -- requirements
Module: instr_fetch_multi

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 4, meaning the maximum number of requests issued but not yet drained downstream (legal range 1..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-004 SHALL have port pc, decoupled.in, addr_t, the fetch address stream.
REQ-005 SHALL have port fetched, decoupled.out, {pc, raw instr}, the in-order fetched instruction stream.
REQ-006 SHALL have port flush, input, 1, which discards all fetches in progress.
REQ-007 SHALL have port mem_req, decoupled.out, mem request {a, we, be, d}, the memory request channel.
REQ-008 SHALL have port mem_resp, decoupled.in, 32, the in-order memory read data.

Function
REQ-009 SHALL keep three counters, each $clog2(MAX_INFLIGHT+1) bits wide: outstanding (issued, no response yet), buffered (responded, not drained) and drop_cnt (responses still to be discarded).
REQ-010 SHALL drive mem_req.valid = pc.valid && !flush && (outstanding + buffered) < MAX_INFLIGHT, using registered counts only, so a drain in the same cycle does not free a slot until the next cycle.
REQ-011 SHALL drive mem_req.a = pc.data and we = 0; be and d are don't-care.
REQ-012 SHALL drive pc.ready = mem_req.valid && mem_req.ready, consuming each PC at issue time, not at drain time.
REQ-013 SHALL record the PC of each issued request in a ring of MAX_INFLIGHT entries at the tail pointer; the tail advances on issue.
REQ-014 SHALL hold mem_resp.ready = 1 at all times after reset, relying on the credit limit in REQ-010; a response arriving with outstanding == 0 and drop_cnt == 0 is an assertion failure.
REQ-015 SHALL count a response as discarded when drop_cnt > 0 (drop_cnt decrements by 1); otherwise SHALL write the response to the ring at the response pointer, advance that pointer, decrement outstanding and increment buffered.
REQ-016 SHALL, when buffered > 0, present the head entry on fetched with fetched.valid = 1.
REQ-017 SHALL, when buffered == 0 and drop_cnt == 0, bypass mem_resp to fetched combinationally: fetched.valid = mem_resp.valid, raw = mem_resp.data, pc = head PC (zero-cycle latency).
REQ-018 SHALL, when a bypassed response is drained in its arrival cycle, neither write it to the ring nor increment buffered; head and response pointers both advance.
REQ-019 SHALL deliver fetched output strictly in issue order; fetched.data SHALL stay stable while fetched.valid && !fetched.ready.
REQ-020 SHALL, on drain (fetched.valid && fetched.ready), advance head and decrement buffered unless the entry was bypassed.
REQ-021 SHALL, while flush is high, force fetched.valid = 0, mem_req.valid = 0 and pc.ready = 0.
REQ-022 SHALL, at the end of a flush cycle, set buffered to 0, align head, tail and response pointers, and set drop_cnt = drop_cnt + outstanding - (mem_resp.valid ? 1 : 0), with the decrement taken from drop_cnt first, then from outstanding; outstanding becomes 0.
REQ-023 SHALL allow new issue after a flush while drop_cnt > 0, subject to (outstanding + buffered + drop_cnt) < MAX_INFLIGHT; this credit form supersedes REQ-010 in general.
REQ-024 SHALL handle simultaneous issue, response and drain in one cycle, with each counter applying all three deltas together.
REQ-025 SHALL, with MAX_INFLIGHT = 1, behave as a single-request fetcher with bypass.

Reset
REQ-026 SHALL, with rst low at a clock edge, zero all counters and pointers and drive fetched.valid = 0, mem_req.valid = 0 and pc.ready = 0 in the following cycle.
REQ-027 SHALL, on reset mid-operation, abandon outstanding responses without tracking them; the system resets memory together with this block.
REQ-028 SHALL leave ring data contents unreset.

Structure
REQ-029 SHALL place fetch_entry_t {pc, raw} and the count-width function in the shared types package.
REQ-030 SHALL implement the ring plus head, tail and response pointers as one sub-module, fetch_ring.

Verification
REQ-031 SHALL cover: MAX_INFLIGHT=4, mem_req.ready=1, 1-cycle memory, PCs 0x0,0x4,0x8,0xC,0x10 -> 4 issues back-to-back, 5th stalls until the first drain, output in order with raw matching memory.
REQ-032 SHALL cover: response with empty buffer and fetched.ready=1 -> fetched.valid in the same cycle, pc=0x100, buffered stays 0.
REQ-033 SHALL cover: fetched.ready=0 for 10 cycles with 4 issued -> buffered=4, mem_req.valid=0, then 4 drains in 4 cycles with data stable throughout.
REQ-034 SHALL cover: flush with outstanding=3, one response arriving in the flush cycle -> drop_cnt=2, the next 2 responses discarded, the new PC 0x200 delivered first.
REQ-035 SHALL cover: back-to-back flush while drop_cnt=2 and outstanding=1 -> drop_cnt=3, credit limit respected.
REQ-036 SHALL cover: rst low mid-stream -> next cycle all valids are 0 and counters are 0.

Source files
------------

// File: rtl/instr_fetch_multi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch_multi_pkg                                                |
// | Shared types and width helpers for the multi-outstanding fetcher.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package instr_fetch_multi_pkg;

    typedef logic [31:0] addr_t;

    typedef struct packed {
        addr_t       pc;
        logic [31:0] raw;
    } fetch_entry_t;

    typedef struct packed {
        addr_t       a;
        logic        we;
        logic [3:0]  be;
        logic [31:0] d;
    } mem_req_t;

    // Width that can hold every value 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_multi_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch_multi_if                                                 |
// | PC, fetched, flush and memory channels of the fetcher, plus counters.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface instr_fetch_multi_if
    import instr_fetch_multi_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4
);
    localparam int c_CW = cnt_width(MAX_INFLIGHT);

    logic            pc_valid;
    logic            pc_ready;
    addr_t           pc_data;

    logic            fetched_valid;
    logic            fetched_ready;
    fetch_entry_t    fetched_data;

    logic            flush;

    logic            mem_req_valid;
    logic            mem_req_ready;
    mem_req_t        mem_req_data;

    logic            mem_resp_valid;
    logic            mem_resp_ready;
    logic [31:0]     mem_resp_data;

    logic [c_CW-1:0] dbg_outstanding;
    logic [c_CW-1:0] dbg_buffered;
    logic [c_CW-1:0] dbg_drop_cnt;

    modport master (
        input  pc_valid, pc_data, output pc_ready,
        output fetched_valid, fetched_data, input fetched_ready,
        input  flush,
        output mem_req_valid, mem_req_data, input mem_req_ready,
        input  mem_resp_valid, mem_resp_data, output mem_resp_ready,
        output dbg_outstanding, dbg_buffered, dbg_drop_cnt
    );

    modport slave (
        output pc_valid, pc_data, input pc_ready,
        input  fetched_valid, fetched_data, output fetched_ready,
        output flush,
        input  mem_req_valid, mem_req_data, output mem_req_ready,
        output mem_resp_valid, mem_resp_data, input mem_resp_ready,
        input  dbg_outstanding, dbg_buffered, dbg_drop_cnt
    );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_multi_ring.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_ring                                                           |
// | PC/data ring with head (drain), tail (issue) and response pointers.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_ring
    import instr_fetch_multi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_push,
    input  wire addr_t        i_push_pc,
    input  wire logic         i_resp_adv,
    input  wire logic         i_resp_wr,
    input  wire logic [31:0]  i_resp_raw,
    input  wire logic         i_pop,
    input  wire logic         i_align,
    output fetch_entry_t      o_head
);
    localparam int c_PW = ptr_width(DEPTH);

    addr_t           r_pc_mem  [DEPTH];
    logic [31:0]     r_raw_mem [DEPTH];
    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [c_PW-1:0] r_resp;

    function automatic logic [c_PW-1:0] next_ptr(input logic [c_PW-1:0] p);
        return (p == c_PW'(DEPTH - 1)) ? '0 : p + c_PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_resp <= '0;
        end else if (i_align) begin
            // Everything in flight is abandoned; restart from the issue point.
            r_head <= r_tail;
            r_resp <= r_tail;
        end else begin
            if (i_push)     r_tail <= next_ptr(r_tail);
            if (i_resp_adv) r_resp <= next_ptr(r_resp);
            if (i_pop)      r_head <= next_ptr(r_head);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push)    r_pc_mem[r_tail]  <= i_push_pc;
        if (i_resp_wr) r_raw_mem[r_resp] <= i_resp_raw;
    end

    assign o_head = fetch_entry_t'{pc: r_pc_mem[r_head], raw: r_raw_mem[r_head]};

endmodule
`default_nettype wire

// File: rtl/instr_fetch_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch_multi                                                    |
// | Credit-limited in-order fetcher with response bypass and flush drop. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module instr_fetch_multi
    import instr_fetch_multi_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    instr_fetch_multi_if.master bus
);
    localparam int c_CW = cnt_width(MAX_INFLIGHT);
    localparam int c_SW = c_CW + 2;
    localparam logic [c_SW-1:0] c_MAX = c_SW'(MAX_INFLIGHT);

    logic [c_CW-1:0] r_outstanding;
    logic [c_CW-1:0] r_buffered;
    logic [c_CW-1:0] r_drop_cnt;

    logic            w_run;
    logic [c_SW-1:0] w_inflight;
    logic            w_issue;
    logic            w_resp;
    logic            w_discard;
    logic            w_keep;
    logic            w_bypass_mode;
    logic            w_drain;
    logic            w_bypass_drain;
    fetch_entry_t    w_head;

    assign w_run = rst;

    // Dropped-but-pending responses still occupy memory-side slots.
    assign w_inflight = c_SW'(r_outstanding) + c_SW'(r_buffered) + c_SW'(r_drop_cnt);

    assign bus.mem_req_valid  = w_run && bus.pc_valid && !bus.flush && (w_inflight < c_MAX);
    assign bus.mem_req_data   = mem_req_t'{a: bus.pc_data, we: 1'b0, be: 4'hF, d: 32'h0};
    assign bus.pc_ready       = bus.mem_req_valid && bus.mem_req_ready;
    assign w_issue            = bus.pc_ready;

    assign bus.mem_resp_ready = w_run;
    assign w_resp             = w_run && bus.mem_resp_valid;
    assign w_discard          = w_resp && (r_drop_cnt != '0);
    assign w_keep             = w_resp && (r_drop_cnt == '0);

    assign w_bypass_mode      = (r_buffered == '0) && (r_drop_cnt == '0);
    assign bus.fetched_valid  = w_run && !bus.flush &&
                                ((r_buffered != '0) || (w_bypass_mode && bus.mem_resp_valid));
    assign bus.fetched_data   = w_bypass_mode ?
                                fetch_entry_t'{pc: w_head.pc, raw: bus.mem_resp_data} : w_head;
    assign w_drain            = bus.fetched_valid && bus.fetched_ready;
    assign w_bypass_drain     = w_drain && (r_buffered == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_outstanding <= '0;
            r_buffered    <= '0;
            r_drop_cnt    <= '0;
        end else if (bus.flush) begin
            // A response landing in the flush cycle is retired from the sum.
            r_drop_cnt    <= r_drop_cnt + r_outstanding - c_CW'(w_resp);
            r_outstanding <= '0;
            r_buffered    <= '0;
        end else begin
            r_drop_cnt    <= r_drop_cnt - c_CW'(w_discard);
            r_outstanding <= r_outstanding + c_CW'(w_issue) - c_CW'(w_keep);
            r_buffered    <= r_buffered + c_CW'(w_keep && !w_bypass_drain)
                                        - c_CW'(w_drain && !w_bypass_drain);
        end
    end

    fetch_ring #(
        .DEPTH (MAX_INFLIGHT)
    ) u_ring (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_issue),
        .i_push_pc  (bus.pc_data),
        .i_resp_adv (w_keep && !bus.flush),
        .i_resp_wr  (w_keep && !w_bypass_drain && !bus.flush),
        .i_resp_raw (bus.mem_resp_data),
        .i_pop      (w_drain),
        .i_align    (bus.flush),
        .o_head     (w_head)
    );

    assign bus.dbg_outstanding = r_outstanding;
    assign bus.dbg_buffered    = r_buffered;
    assign bus.dbg_drop_cnt    = r_drop_cnt;

    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst)
        !(bus.mem_resp_valid && (r_outstanding == '0) && (r_drop_cnt == '0)));

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_fetch_multi                                                 |
// | Directed scenarios plus random traffic against a queue-based model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_instr_fetch_multi;
    import instr_fetch_multi_pkg::*;

    localparam int c_MAXI = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_multi_if #(.MAX_INFLIGHT(c_MAXI)) bus ();
    instr_fetch_multi #(.MAX_INFLIGHT(c_MAXI)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { logic [31:0] pc; bit resp; } exp_t;
    typedef struct { logic [31:0] a; int ep; int rdy; } mreq_t;

    exp_t        exp_q[$];
    mreq_t       mq[$];
    logic [31:0] pc_src[$];
    logic [31:0] drained[$];

    int epoch, cyc, last_rdy, n_issue;
    bit synced;
    int checks, failures;

    bit d_rst, d_flush, d_pc_en, d_fready, d_mready;
    int d_lat;

    bit ob_fv, ob_mv, ob_rv;
    logic [31:0] ob_fpc, ob_fraw;
    int ob_out, ob_buf, ob_drop;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic step();
        int stale, out_m, buf_m, r;
        bit live_resp, e_mv, e_fv, rv;
        exp_t e;
        mreq_t m, h;
        bit found;
        @(posedge clk);
        #1;
        cyc++;
        rst                = d_rst;
        bus.flush          = d_flush;
        bus.pc_valid       = d_pc_en && (pc_src.size() > 0);
        bus.pc_data        = (pc_src.size() > 0) ? pc_src[0] : 32'h0;
        bus.mem_req_ready  = d_mready;
        bus.fetched_ready  = d_fready;
        rv                 = d_rst && (mq.size() > 0) && (mq[0].rdy <= cyc);
        bus.mem_resp_valid = rv;
        bus.mem_resp_data  = (mq.size() > 0) ? memf(mq[0].a) : 32'h0;
        @(negedge clk);

        stale = 0;
        foreach (mq[i]) if (mq[i].ep != epoch) stale++;
        out_m = 0; buf_m = 0;
        foreach (exp_q[i]) if (exp_q[i].resp) buf_m++; else out_m++;
        live_resp = rv && (mq[0].ep == epoch);
        e_mv = d_rst && bus.pc_valid && !d_flush && ((exp_q.size() + stale) < c_MAXI);
        e_fv = d_rst && !d_flush && (exp_q.size() > 0) && (exp_q[0].resp || live_resp);

        if (synced) begin
            chk("mem_req_valid", bus.mem_req_valid, e_mv);
            chk("pc_ready", bus.pc_ready, e_mv && d_mready);
            chk("fetched_valid", bus.fetched_valid, e_fv);
            chk("mem_resp_ready", bus.mem_resp_ready, d_rst);
            chk("outstanding", bus.dbg_outstanding, out_m);
            chk("buffered", bus.dbg_buffered, buf_m);
            chk("drop_cnt", bus.dbg_drop_cnt, stale);
            if (e_mv) begin
                chk("mem_req_a", bus.mem_req_data.a, bus.pc_data);
                chk("mem_req_we", bus.mem_req_data.we, 1'b0);
            end
            if (e_fv) begin
                chk("fetched_pc", bus.fetched_data.pc, exp_q[0].pc);
                chk("fetched_raw", bus.fetched_data.raw, memf(exp_q[0].pc));
            end
        end

        ob_fv = bus.fetched_valid; ob_mv = bus.mem_req_valid; ob_rv = rv;
        ob_fpc = bus.fetched_data.pc; ob_fraw = bus.fetched_data.raw;
        ob_out = int'(bus.dbg_outstanding); ob_buf = int'(bus.dbg_buffered);
        ob_drop = int'(bus.dbg_drop_cnt);
        if (bus.fetched_valid && bus.fetched_ready) drained.push_back(bus.fetched_data.pc);
        if (bus.pc_ready) n_issue++;

        if (!d_rst) begin
            exp_q.delete();
            mq.delete();
            last_rdy = 0;
            synced = 1'b1;
        end else begin
            if (rv) begin
                h = mq.pop_front();
                if (!d_flush && h.ep == epoch) begin
                    found = 1'b0;
                    foreach (exp_q[i]) if (!found && !exp_q[i].resp) begin
                        exp_q[i].resp = 1'b1;
                        found = 1'b1;
                    end
                    chk("resp_has_owner", found, 1'b1);
                end
            end
            if (e_fv && d_fready) void'(exp_q.pop_front());
            if (e_mv && d_mready) begin
                e.pc = pc_src[0]; e.resp = 1'b0;
                exp_q.push_back(e);
                r = cyc + d_lat;
                if (r < last_rdy) r = last_rdy;
                m.a = pc_src[0]; m.ep = epoch; m.rdy = r;
                mq.push_back(m);
                last_rdy = r;
                void'(pc_src.pop_front());
            end
            if (d_flush) begin
                exp_q.delete();
                epoch++;
            end
        end
    endtask

    task automatic idle();
        d_pc_en = 1'b0; d_flush = 1'b0; d_fready = 1'b1; d_mready = 1'b1;
        for (int i = 0; i < 60 && (exp_q.size() + mq.size()) != 0; i++) step();
        chk("idle_drained", exp_q.size() + mq.size(), 0);
    endtask

    task automatic rand_knobs();
        d_pc_en  = ($urandom_range(0, 9) < 8);
        d_fready = ($urandom_range(0, 9) < 7);
        d_mready = ($urandom_range(0, 9) < 8);
        d_flush  = ($urandom_range(0, 39) == 0);
        d_lat    = $urandom_range(1, 4);
        while (pc_src.size() < 2) pc_src.push_back($urandom & 32'hFFFF_FFFC);
    endtask

    initial begin
        logic [31:0] ord [5];
        bit seen;
        ord = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        checks = 0; failures = 0; epoch = 0; cyc = 0; last_rdy = 0; synced = 1'b0;
        d_rst = 1'b0; d_flush = 1'b0; d_pc_en = 1'b0; d_fready = 1'b0; d_mready = 1'b1; d_lat = 1;
        rst = 1'b0; bus.flush = 1'b0; bus.pc_valid = 1'b0; bus.pc_data = '0;
        bus.mem_req_ready = 1'b0; bus.fetched_ready = 1'b0;
        bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;

        step(); step();
        chk("rst_fvalid", ob_fv, 1'b0);
        chk("rst_mvalid", ob_mv, 1'b0);
        chk("rst_out", ob_out, 0);
        chk("rst_buf", ob_buf, 0);
        chk("rst_drop", ob_drop, 0);
        d_rst = 1'b1;

        // Four back-to-back issues, fifth stalls, then in-order drains.
        pc_src = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        d_pc_en = 1'b1; d_fready = 1'b0; d_lat = 1; n_issue = 0;
        repeat (10) step();
        chk("hold_issues", n_issue, 4);
        chk("hold_buffered", ob_buf, 4);
        chk("hold_mreq_valid", ob_mv, 1'b0);
        drained.delete();
        d_fready = 1'b1;
        repeat (4) step();
        chk("drain_4_in_4", drained.size(), 4);
        idle();
        chk("order_count", drained.size(), 5);
        for (int i = 0; i < 5 && i < drained.size(); i++) chk("order_pc", drained[i], ord[i]);

        // Zero-latency bypass from an empty buffer.
        pc_src = '{32'h100};
        d_pc_en = 1'b1; d_lat = 2; d_fready = 1'b1; seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (ob_rv) seen = 1'b1;
        end
        chk("byp_seen", seen, 1'b1);
        chk("byp_fvalid", ob_fv, 1'b1);
        chk("byp_pc", ob_fpc, 32'h100);
        chk("byp_raw", ob_fraw, 32'h0100FEFF);
        step();
        chk("byp_buffered", ob_buf, 0);

        // Flush with three outstanding and one response in the flush cycle.
        idle();
        pc_src = '{32'h300, 32'h304, 32'h308};
        d_pc_en = 1'b1; d_lat = 3;
        repeat (3) step();
        d_flush = 1'b1; pc_src.push_back(32'h200);
        step();
        chk("fl_out", ob_out, 3);
        chk("fl_resp", ob_rv, 1'b1);
        d_flush = 1'b0; drained.delete();
        step();
        chk("fl_drop", ob_drop, 2);
        idle();
        chk("fl_count", drained.size(), 1);
        if (drained.size() > 0) chk("fl_first", drained[0], 32'h200);

        // Second flush while drops are pending; credit includes drops.
        pc_src = '{32'h400, 32'h404};
        d_pc_en = 1'b1; d_lat = 8;
        step(); step();
        d_flush = 1'b1; pc_src.push_back(32'h500);
        step();
        d_flush = 1'b0;
        step();
        d_flush = 1'b1;
        step();
        chk("fl2_drop_pre", ob_drop, 2);
        chk("fl2_out_pre", ob_out, 1);
        d_flush = 1'b0; d_lat = 1; drained.delete();
        pc_src.push_back(32'h600); pc_src.push_back(32'h604);
        step();
        chk("fl2_drop", ob_drop, 3);
        step();
        chk("fl2_credit_stall", ob_mv, 1'b0);
        idle();
        if (drained.size() > 0) chk("fl2_first", drained[0], 32'h600);
        else chk("fl2_first_seen", drained.size(), 1);
        pc_src.delete();

        // Reset mid-stream.
        repeat (30) begin rand_knobs(); d_flush = 1'b0; step(); end
        d_rst = 1'b0;
        step(); step();
        chk("mid_rst_fvalid", ob_fv, 1'b0);
        chk("mid_rst_mvalid", ob_mv, 1'b0);
        chk("mid_rst_out", ob_out, 0);
        chk("mid_rst_buf", ob_buf, 0);
        chk("mid_rst_drop", ob_drop, 0);
        d_rst = 1'b1; pc_src.delete();

        repeat (2500) begin rand_knobs(); step(); end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
